// File: rtl/dmem_responder_if.sv
// Core data-memory request bus: one-cycle requests, registered read data back.
interface dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic        data_en;
  logic        write_en;
  logic [31:0] data_o;

  modport master (
    output addr,
    output data_i,
    output data_en,
    output write_en,
    input  data_o
  );

  modport slave (
    input  addr,
    input  data_i,
    input  data_en,
    input  write_en,
    output data_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus memory-mapped exit, LED, 64-bit cycle counter and a
// console byte FIFO. Every request completes in one cycle; read data is registered.
module dmem_responder #(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [3:0]         led,
  output logic               done,
  output logic [31:0]        exit_code,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               bad_access
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [31:0] AddrExit  = 32'h600D_600D;
  localparam logic [31:0] AddrLed   = 32'hF000_0000;
  localparam logic [31:0] AddrCycLo = 32'hF000_0004;
  localparam logic [31:0] AddrCycHi = 32'hF000_0008;
  localparam logic [31:0] AddrCon   = 32'hF000_000C;

  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [31:0]   data_o_q, data_o_d;
  logic [3:0]    led_q, led_d;
  logic          done_q, done_d;
  logic [31:0]   exit_q, exit_d;
  logic [63:0]   cyc_q, cyc_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;

  logic          hit_ram, hit_exit, hit_led, hit_cyc_lo, hit_cyc_hi, hit_con, unmapped;
  logic [AW-1:0] word_idx;
  logic          rd_req, wr_req;
  logic          fifo_empty, fifo_full, push, pop, push_acc;
  logic [31:0]   rd_data;

  // Address decode
  assign word_idx   = bus.addr[AW+1:2];
  assign hit_ram    = (bus.addr >> (AW + 2)) == 32'd0;
  assign hit_exit   = bus.addr == AddrExit;
  assign hit_led    = bus.addr == AddrLed;
  assign hit_cyc_lo = bus.addr == AddrCycLo;
  assign hit_cyc_hi = bus.addr == AddrCycHi;
  assign hit_con    = bus.addr == AddrCon;
  assign unmapped   = !(hit_ram || hit_exit || hit_led || hit_cyc_lo || hit_cyc_hi || hit_con);

  assign rd_req = bus.data_en && !bus.write_en;
  assign wr_req = bus.data_en && bus.write_en;

  assign fifo_empty = cnt_q == 5'd0;
  assign fifo_full  = cnt_q == 5'(FIFO_DEPTH);
  assign pop        = !fifo_empty && tx_ready;
  assign push       = wr_req && hit_con;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push_acc   = push && (!fifo_full || pop);

  always_comb begin
    rd_data = 32'd0;
    if (hit_ram) begin
      rd_data = mem[word_idx];
    end else if (hit_exit) begin
      rd_data = {31'd0, done_q};
    end else if (hit_led) begin
      rd_data = {28'd0, led_q};
    end else if (hit_cyc_lo) begin
      rd_data = cyc_q[31:0];
    end else if (hit_cyc_hi) begin
      rd_data = shadow_q;
    end else if (hit_con) begin
      rd_data = {23'd0, cnt_q, 1'b0, ovf_q, fifo_full, fifo_empty};
    end
  end

  always_comb begin
    data_o_d = data_o_q;
    led_d    = led_q;
    done_d   = done_q;
    exit_d   = exit_q;
    shadow_d = shadow_q;
    cyc_d    = cyc_q + 64'd1;
    bad_d    = bus.data_en && unmapped;
    if (rd_req) begin
      data_o_d = rd_data;
      if (hit_cyc_lo) begin
        shadow_d = cyc_q[63:32];
      end
    end
    if (wr_req && hit_led) begin
      led_d = bus.data_i[3:0];
    end
    if (wr_req && hit_exit && !done_q) begin
      done_d = 1'b1;
      exit_d = bus.data_i;
    end
  end

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q || (push && fifo_full && !pop);
    unique case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_o_q <= 32'd0;
      led_q    <= 4'd0;
      done_q   <= 1'b0;
      exit_q   <= 32'd0;
      cyc_q    <= 64'd0;
      shadow_q <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= 5'd0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      data_o_q <= data_o_d;
      led_q    <= led_d;
      done_q   <= done_d;
      exit_q   <= exit_d;
      cyc_q    <= cyc_d;
      shadow_q <= shadow_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
    end
  end

  // Storage arrays are not reset; reset only blocks a write issued during reset.
  always_ff @(posedge clk) begin
    if (reset && wr_req && hit_ram) begin
      mem[word_idx] <= bus.data_i;
    end
    if (reset && push_acc) begin
      fifo_mem[wr_ptr_q] <= bus.data_i[7:0];
    end
  end

  assign bus.data_o = data_o_q;
  assign led        = led_q;
  assign done       = done_q;
  assign exit_code  = exit_q;
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_mem[rd_ptr_q];
  assign bad_access = bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus hand-written multi-cycle sequences,
// with read results and console bytes tracked through scoreboard queues.
module tb_dmem_responder;

  localparam logic [31:0] AddrExit  = 32'h600D_600D;
  localparam logic [31:0] AddrLed   = 32'hF000_0000;
  localparam logic [31:0] AddrCycLo = 32'hF000_0004;
  localparam logic [31:0] AddrCycHi = 32'hF000_0008;
  localparam logic [31:0] AddrCon   = 32'hF000_000C;
  localparam logic [31:0] AddrBad   = 32'hF000_0010;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        tx_ready;
  logic [3:0]  led;
  logic        done;
  logic [31:0] exit_code;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        bad_access;

  dmem_responder_if bus ();

  dmem_responder #(
    .MEM_WORDS  (4096),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .led        (led),
    .done       (done),
    .exit_code  (exit_code),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .bad_access (bad_access)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_q [$];
  string       nm_q  [$];
  logic [7:0]  tx_model [$];
  logic        ovf_model = 1'b0;
  vec_t        vecs [14];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] con_status();
    logic [4:0] c;
    c = 5'(tx_model.size());
    return {23'd0, c, 1'b0, ovf_model, c == 5'd16, c == 5'd0};
  endfunction

  // Called at a negedge; issues one request across the next posedge and checks read data after.
  task automatic do_req(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic chk, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    bus.addr     = a;
    bus.write_en = wr;
    bus.data_i   = wd;
    bus.data_en  = 1'b1;
    if (chk) begin
      exp_q.push_back(exp);
      nm_q.push_back(nm);
    end
    @(negedge clk);
    bus.data_en  = 1'b0;
    bus.write_en = 1'b0;
    if (chk) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check(n, bus.data_o, e);
    end
  endtask

  task automatic con_push(input logic [7:0] b);
    logic pop_now, full_now;
    pop_now  = (tx_model.size() > 0) && tx_ready;
    full_now = tx_model.size() >= 16;
    if (pop_now) begin
      check("tx_head_on_push", 32'(tx_data), 32'(tx_model[0]));
      void'(tx_model.pop_front());
    end
    if (!full_now || pop_now) tx_model.push_back(b);
    else ovf_model = 1'b1;
    do_req(AddrCon, 1'b1, {24'd0, b}, 1'b0, 32'd0, "");
  endtask

  task automatic drain(input int n);
    logic [7:0] b;
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = tx_model.pop_front();
      check("drain_valid", 32'(tx_valid), 32'd1);
      check("drain_byte", 32'(tx_data), 32'(b));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("drain_end_valid", 32'(tx_valid), 32'(tx_model.size() != 0));
  endtask

  task automatic do_reset();
    bus.data_en = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tx_model.delete();
    ovf_model = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    tx_ready     = 1'b0;
    bus.addr     = 32'd0;
    bus.data_i   = 32'd0;
    bus.data_en  = 1'b0;
    bus.write_en = 1'b0;

    vecs[0]  = '{32'h0000_0100, 1'b1, 32'hDEADBEEF, 32'h0,        "ram_wr_100"};
    vecs[1]  = '{32'h0000_0102, 1'b0, 32'h0,        32'hDEADBEEF, "ram_rd_102"};
    vecs[2]  = '{32'h0000_0104, 1'b1, 32'h1234_5678, 32'h0,       "ram_wr_104"};
    vecs[3]  = '{32'h0000_0107, 1'b0, 32'h0,        32'h1234_5678, "ram_rd_107"};
    vecs[4]  = '{32'h0000_3FFC, 1'b1, 32'hCAFE_F00D, 32'h0,       "ram_wr_last"};
    vecs[5]  = '{32'h0000_3FFC, 1'b0, 32'h0,        32'hCAFE_F00D, "ram_rd_last"};
    vecs[6]  = '{32'h0000_4000, 1'b0, 32'h0,        32'h0,        "rd_past_ram"};
    vecs[7]  = '{AddrLed,       1'b1, 32'h0000_00A5, 32'h0,       "led_wr"};
    vecs[8]  = '{AddrLed,       1'b0, 32'h0,        32'h5,        "led_rd"};
    vecs[9]  = '{AddrCycLo,     1'b1, 32'hFFFF_FFFF, 32'h0,       "cyc_wr_ignored"};
    vecs[10] = '{AddrExit,      1'b0, 32'h0,        32'h0,        "exit_rd_idle"};
    vecs[11] = '{AddrCon,       1'b0, 32'h0,        32'h1,        "con_rd_empty"};
    vecs[12] = '{32'h600D_600C, 1'b0, 32'h0,        32'h0,        "rd_near_exit"};
    vecs[13] = '{32'h0000_0100, 1'b0, 32'h0,        32'hDEADBEEF, "ram_rd_100"};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_o", bus.data_o, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_bad_access", 32'(bad_access), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    do_req(AddrCycLo, 1'b0, 32'd0, 1'b1, 32'd1, "cyc_first_edge");
    do_req(AddrCycHi, 1'b0, 32'd0, 1'b1, 32'd0, "cyc_hi_after_rst");

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].addr, vecs[i].wr, vecs[i].wdata, !vecs[i].wr, vecs[i].exp, vecs[i].name);
    end

    // Overflow with the sink stalled, then drain in order
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) con_push(8'(i));
    do_req(AddrCon, 1'b0, 32'd0, 1'b1, con_status(), "con_full_ovf");
    drain(16);
    do_req(AddrCon, 1'b0, 32'd0, 1'b1, con_status(), "con_empty_ovf");

    // Push while full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 16; i++) con_push(8'(8'h20 + i));
    tx_ready = 1'b1;
    con_push(8'h77);
    tx_ready = 1'b0;
    do_req(AddrCon, 1'b0, 32'd0, 1'b1, con_status(), "con_full_no_ovf");
    drain(16);

    // Exit: first write wins and sticks
    do_req(AddrExit, 1'b1, 32'd7, 1'b0, 32'd0, "");
    do_req(AddrExit, 1'b1, 32'd9, 1'b0, 32'd0, "");
    check("exit_done", 32'(done), 32'd1);
    check("exit_code_first", exit_code, 32'd7);
    repeat (2) @(negedge clk);
    check("exit_code_hold", exit_code, 32'd7);
    do_req(AddrExit, 1'b0, 32'd0, 1'b1, 32'd1, "exit_rd_done");

    // Snapshot and low-to-high carry near 2^32
    force dut.cyc_q = 64'h0000_0002_FFFF_FFFE;
    #1 release dut.cyc_q;
    do_req(AddrCycLo, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, "cyc_lo_pre_carry");
    repeat (5) @(negedge clk);
    do_req(AddrCycHi, 1'b0, 32'd0, 1'b1, 32'd2, "cyc_hi_snapshot");
    do_req(AddrCycLo, 1'b0, 32'd0, 1'b1, 32'd5, "cyc_lo_post_carry");
    do_req(AddrCycHi, 1'b0, 32'd0, 1'b1, 32'd3, "cyc_hi_carry");

    // Data hold, unmapped accesses
    do_req(32'h100, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF, "ram_rd_before_bad");
    @(negedge clk);
    check("data_o_hold", bus.data_o, 32'hDEADBEEF);
    do_req(AddrBad, 1'b0, 32'd0, 1'b1, 32'd0, "bad_rd_data");
    check("bad_rd_pulse", 32'(bad_access), 32'd1);
    @(negedge clk);
    check("bad_rd_pulse_end", 32'(bad_access), 32'd0);
    do_req(AddrLed, 1'b1, 32'h9, 1'b0, 32'd0, "");
    do_req(AddrBad, 1'b1, 32'hF, 1'b0, 32'd0, "");
    check("bad_wr_pulse", 32'(bad_access), 32'd1);
    do_req(AddrLed, 1'b0, 32'd0, 1'b1, 32'h9, "led_after_bad_wr");

    // Mid-stream reset with FIFO non-empty and a request pending
    check("tx_valid_before_push", 32'(tx_valid), 32'd0);
    con_push(8'hAB);
    check("tx_valid_after_push", 32'(tx_valid), 32'd1);
    check("tx_data_after_push", 32'(tx_data), 32'hAB);
    con_push(8'hCD);
    reset        = 1'b0;
    bus.addr     = 32'h100;
    bus.data_i   = 32'h0;
    bus.write_en = 1'b1;
    bus.data_en  = 1'b1;
    repeat (2) @(negedge clk);
    bus.data_en  = 1'b0;
    bus.write_en = 1'b0;
    reset        = 1'b1;
    tx_model.delete();
    ovf_model    = 1'b0;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_exit_code", exit_code, 32'd0);
    check("mid_rst_data_o", bus.data_o, 32'd0);
    do_req(32'h100, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF, "ram_kept_100");
    do_req(32'h104, 1'b0, 32'd0, 1'b1, 32'h1234_5678, "ram_kept_104");
    do_req(AddrCon, 1'b0, 32'd0, 1'b1, con_status(), "con_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 4096: RAM depth in 32-bit words, power of two.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16: console FIFO depth in entries, power of two, max 16.
REQ-003 The module SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 The module SHALL have port addr, input, 32 bits: request address from the core's data-memory interface.
REQ-006 The module SHALL have port data_i, input, 32 bits: write data from the core.
REQ-007 The module SHALL have port data_en, input, 1 bit: request valid.
REQ-008 The module SHALL have port write_en, input, 1 bit: 1 = write, 0 = read; meaningful only when data_en=1.
REQ-009 The module SHALL have port data_o, output, 32 bits: registered read data.
REQ-010 The module SHALL have port led, output, 4 bits: LED register.
REQ-011 The module SHALL have port done, output, 1 bit: sticky program-exit flag.
REQ-012 The module SHALL have port exit_code, output, 32 bits: value written at exit.
REQ-013 The module SHALL have port tx_valid, output, 1 bit: console byte available.
REQ-014 The module SHALL have port tx_data, output, 8 bits: console byte at the FIFO head.
REQ-015 The module SHALL have port tx_ready, input, 1 bit: console sink accepts tx_data.
REQ-016 The module SHALL have port bad_access, output, 1 bit: one-cycle pulse for an unmapped access.

Function
REQ-017 The module SHALL decode the address map as follows; there is no ready/stall signal, and every request completes in one cycle.
- RAM: addr < MEM_WORDS*4, word index addr[log2(MEM_WORDS)+1:2], addr[1:0] ignored.
- EXIT: addr == 32'h600d600d, exact 32-bit match.
- LED: 32'hF000_0000.
- CYC_LO: 32'hF000_0004.
- CYC_HI: 32'hF000_0008.
- CON: 32'hF000_000C.
REQ-018 On a read (data_en=1, write_en=0), data_o SHALL present the addressed value on the cycle after the request edge (latency 1).
REQ-019 When data_en=0, data_o SHALL hold its previous value.
REQ-020 A RAM write SHALL commit at the request edge; a read of the same word on the next cycle SHALL return the new data.
REQ-021 A write to EXIT SHALL set done=1 and exit_code=data_i only if done==0 (first write wins); done SHALL remain 1 until reset; a read of EXIT SHALL return {31'b0, done}.
REQ-022 A write to LED SHALL set led=data_i[3:0]; a read of LED SHALL return {28'b0, led}.
REQ-023 A 64-bit cycle counter SHALL increment every non-reset cycle and wrap from 2^64-1 to 0.
REQ-024 A read of CYC_LO SHALL return counter[31:0] and snapshot counter[63:32] into a shadow register; a read of CYC_HI SHALL return the shadow value.
REQ-025 A write to CYC_LO or CYC_HI SHALL be ignored.
REQ-026 A write to CON SHALL push data_i[7:0] into the console FIFO.
REQ-027 A read of CON SHALL return a status word:
- bit 0: empty.
- bit 1: full.
- bit 2: overflow (sticky).
- bits 8:4: entry count.
- all other bits: 0.
REQ-028 tx_valid SHALL equal !empty and tx_data SHALL equal the FIFO head; a pop SHALL occur on any edge where tx_valid && tx_ready.
REQ-029 A push while full and without a simultaneous pop SHALL drop the byte and set overflow=1, which holds until reset.
REQ-030 A push while full with a simultaneous pop SHALL be accepted; count SHALL be unchanged.
REQ-031 A push while empty SHALL make tx_valid=1 on the next cycle; the FIFO SHALL have no same-cycle bypass.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 An access (read or write) to any unmapped address SHALL pulse bad_access for exactly the cycle after the request; an unmapped read SHALL return data_o=0; an unmapped write SHALL have no effect.

Reset
REQ-034 When reset=0 at a clk edge, the module SHALL clear data_o, led, done, exit_code, the counter, the shadow register, FIFO pointers/count, overflow and bad_access to 0, with tx_valid=0 thereafter.
REQ-035 Reset SHALL override any request in the same cycle; reset SHALL NOT clear RAM contents.
REQ-036 On the first non-reset edge after reset, the counter SHALL become 1.

Verification
REQ-037 The bench SHALL drive a write of 32'hDEADBEEF to 0x100, then a read of 0x102 -> data_o=32'hDEADBEEF one cycle after the read request.
REQ-038 The bench SHALL drive writes of 7 then 9 to 32'h600d600d -> done=1 and exit_code=7 persist; a later read of EXIT returns 1.
REQ-039 The bench SHALL hold tx_ready=0 and push 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> status = count 16, full=1, overflow=1; then set tx_ready=1 -> bytes 0x00..0x0F are drained in order, followed by empty=1.
REQ-040 The bench SHALL push with the FIFO full while tx_ready=1 -> the new byte is accepted, count stays 16, and overflow stays 0.
REQ-041 The bench SHALL read CYC_LO, let 5 cycles elapse, then read CYC_HI -> CYC_HI returns the high word from the earlier snapshot; with the counter forced near 2^32, the low-to-high carry is verified.
REQ-042 The bench SHALL read 0xF000_0010, then assert reset=0 mid-stream with the FIFO non-empty -> bad_access=1 for one cycle with data_o=0; after reset, tx_valid=0, led=0, done=0, and RAM data written earlier is still readable.
